bp_be_issue_queue_mc: RTL and testbench

- Parametrised successor to the BE single-commit issue FIFO that sits between the FE queue and the BE decode/dispatch stage.
- Holds fetched packets in a circular buffer with three pointers:
  - write pointer (enqueue),
  - speculative read pointer (issue),
  - commit pointer (retire).
- Generalised over depth, payload width and commit width: up to deq_width_p entries retire per cycle.
- Adds a ready margin so upstream stages with pipeline latency can be throttled early.

---
 rtl/bp_be_issue_queue_mc.sv | 159 +++++++++++++++
 tb/tb_bp_be_issue_queue_mc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_issue_queue_mc.sv
//==============================================================================
// Module      : bp_be_issue_queue_mc
// Description : Multi-commit BE issue queue. Circular buffer with write,
//               speculative read and commit pointers; commits up to
//               deq_width_p entries per cycle. Optional performance counters
//               are enabled by defining BP_BE_ISSUE_QUEUE_PERF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bp_be_issue_queue_mc #(
    parameter int width_p        = 64,
    parameter int els_p          = 16,
    parameter int deq_width_p    = 2,
    parameter int ready_margin_p = 0,
    localparam int ptr_w         = $clog2(els_p) + 1,
    localparam int cnt_w         = $clog2(deq_width_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clr_v_i,
    input  logic               roll_v_i,
    input  logic               deq_v_i,
    input  logic [cnt_w-1:0]   deq_cnt_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [ptr_w-1:0]   occupancy_o,
    output logic [ptr_w-1:0]   inflight_o
`ifdef BP_BE_ISSUE_QUEUE_PERF_EN
    ,
    output logic [31:0]        full_cycles_o,
    output logic [31:0]        empty_cycles_o,
    output logic [31:0]        roll_cnt_o
`endif
);

    localparam int               c_idx_w  = ptr_w - 1;
    localparam logic [ptr_w-1:0] c_els    = ptr_w'(els_p);
    localparam logic [ptr_w-1:0] c_margin = ptr_w'(ready_margin_p);

    logic [width_p-1:0] r_mem [els_p];

    logic [ptr_w-1:0] r_wptr;
    logic [ptr_w-1:0] r_rptr;
    logic [ptr_w-1:0] r_cptr;
    logic [ptr_w-1:0] w_wptr_n;
    logic [ptr_w-1:0] w_rptr_n;
    logic [ptr_w-1:0] w_cptr_n;
    logic [ptr_w-1:0] w_occupancy;
    logic [ptr_w-1:0] w_inflight;
    logic [ptr_w-1:0] w_free;
    logic [ptr_w-1:0] w_deq_amt;
    logic             w_enq;
    logic             w_iss;

    assign w_occupancy = r_wptr - r_cptr;
    assign w_inflight  = r_rptr - r_cptr;
    assign w_free      = c_els - w_occupancy;

    assign occupancy_o = w_occupancy;
    assign inflight_o  = w_inflight;
    assign ready_o     = (w_free > c_margin);
    assign v_o         = (r_rptr != r_wptr);
    assign data_o      = r_mem[r_rptr[c_idx_w-1:0]];

    assign w_deq_amt   = deq_v_i ? ptr_w'(deq_cnt_i) : '0;

    always_comb begin
        w_cptr_n = r_cptr + w_deq_amt;
        w_wptr_n = r_wptr;
        w_rptr_n = r_rptr;
        w_enq    = v_i & ready_o & ~clr_v_i;
        w_iss    = yumi_i & v_o & ~clr_v_i & ~roll_v_i;

        // An over-commit must never let the commit pointer pass the read pointer
        if (w_deq_amt > w_inflight) begin
            w_cptr_n = r_rptr;
        end

        if (clr_v_i) begin
            w_rptr_n = w_cptr_n;
            w_wptr_n = w_cptr_n;
        end else if (roll_v_i) begin
            w_rptr_n = w_cptr_n;
            w_wptr_n = r_wptr + ptr_w'(w_enq);
        end else begin
            w_rptr_n = r_rptr + ptr_w'(w_iss);
            w_wptr_n = r_wptr + ptr_w'(w_enq);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
        end else begin
            r_wptr <= w_wptr_n;
            r_rptr <= w_rptr_n;
            r_cptr <= w_cptr_n;
        end
    end

    // Payload storage is deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr[c_idx_w-1:0]] <= data_i;
        end
    end

`ifdef BP_BE_ISSUE_QUEUE_PERF_EN
    logic [31:0] r_full_cycles;
    logic [31:0] r_empty_cycles;
    logic [31:0] r_roll_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_full_cycles  <= '0;
            r_empty_cycles <= '0;
            r_roll_cnt     <= '0;
        end else begin
            if (!ready_o && (r_full_cycles != '1)) begin
                r_full_cycles <= r_full_cycles + 32'd1;
            end
            if (!v_o && (r_empty_cycles != '1)) begin
                r_empty_cycles <= r_empty_cycles + 32'd1;
            end
            if (roll_v_i && !clr_v_i && (r_roll_cnt != '1)) begin
                r_roll_cnt <= r_roll_cnt + 32'd1;
            end
        end
    end

    assign full_cycles_o  = r_full_cycles;
    assign empty_cycles_o = r_empty_cycles;
    assign roll_cnt_o     = r_roll_cnt;
`endif

`ifndef SYNTHESIS
    a_enq_when_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        v_i |-> ready_o)
        else $error("bp_be_issue_queue_mc: enqueue while not ready");

    a_yumi_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> v_o)
        else $error("bp_be_issue_queue_mc: yumi while not valid");

    a_deq_cnt_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        deq_v_i |-> ((deq_cnt_i != '0) && (ptr_w'(deq_cnt_i) <= w_inflight)))
        else $error("bp_be_issue_queue_mc: illegal commit count");
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_be_issue_queue_mc.sv
//==============================================================================
// Module      : tb_bp_be_issue_queue_mc
// Description : Scoreboard bench for bp_be_issue_queue_mc (default build).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bp_be_issue_queue_mc;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        clr_v_i, roll_v_i, deq_v_i, v_i, yumi_i;
    logic [1:0]  deq_cnt_i;
    logic [63:0] data_i;
    logic        ready_o, v_o;
    logic [63:0] data_o;
    logic [4:0]  occupancy_o, inflight_o;

    logic        m_deq_v_i, m_v_i, m_yumi_i;
    logic [1:0]  m_deq_cnt_i;
    logic [63:0] m_data_i;
    logic        m_ready_o, m_v_o;
    logic [63:0] m_data_o;
    logic [4:0]  m_occupancy_o, m_inflight_o;

    int checks = 0;
    int errors = 0;
    int issued = 0;

    logic [63:0] exp_q[$];
    logic [63:0] uc[$];
    int          infl = 0;

    always #5 clk_i = ~clk_i;

    bp_be_issue_queue_mc #(
        .width_p(64), .els_p(16), .deq_width_p(2), .ready_margin_p(0)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .clr_v_i(clr_v_i), .roll_v_i(roll_v_i),
        .deq_v_i(deq_v_i), .deq_cnt_i(deq_cnt_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
        .occupancy_o(occupancy_o), .inflight_o(inflight_o)
    );

    bp_be_issue_queue_mc #(
        .width_p(64), .els_p(16), .deq_width_p(2), .ready_margin_p(2)
    ) dut_m (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .clr_v_i(1'b0), .roll_v_i(1'b0),
        .deq_v_i(m_deq_v_i), .deq_cnt_i(m_deq_cnt_i), .v_i(m_v_i), .data_i(m_data_i),
        .ready_o(m_ready_o), .v_o(m_v_o), .data_o(m_data_o), .yumi_i(m_yumi_i),
        .occupancy_o(m_occupancy_o), .inflight_o(m_inflight_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted issue must present the oldest expected payload
    always @(negedge clk_i) begin
        if (reset_n_i && v_o && yumi_i) begin
            issued++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected actual=%0h required=none", data_o);
            end else begin
                chk("issue_data", data_o, exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus plus the matching queue-model update
    task automatic cyc(input logic v, input logic [63:0] d, input logic y,
                       input logic dv, input logic [1:0] dc, input logic rl, input logic cl);
        int  n;
        bit  rdy;
        v_i = v; data_i = d; yumi_i = y; deq_v_i = dv; deq_cnt_i = dc;
        roll_v_i = rl; clr_v_i = cl;
        rdy = (16 - uc.size()) > 0;
        n = dv ? int'(dc) : 0;
        for (int i = 0; i < n; i++) void'(uc.pop_front());
        infl -= n;
        if (cl) begin
            uc.delete();
            exp_q.delete();
            infl = 0;
        end else begin
            if (rl) begin
                for (int i = infl - 1; i >= 0; i--) exp_q.push_front(uc[i]);
                infl = 0;
            end else if (y) begin
                infl++;
            end
            if (v && rdy) begin
                uc.push_back(d);
                exp_q.push_back(d);
            end
        end
        @(posedge clk_i);
        #1;
        v_i = 0; yumi_i = 0; deq_v_i = 0; deq_cnt_i = 0; roll_v_i = 0; clr_v_i = 0;
    endtask

    task automatic chk_state(input string nm);
        chk({nm, "_occ"},   occupancy_o, uc.size());
        chk({nm, "_infl"},  inflight_o, infl);
        chk({nm, "_v"},     v_o, exp_q.size() != 0);
        chk({nm, "_ready"}, ready_o, (16 - uc.size()) > 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i = 0;
        v_i = 0; data_i = 0; yumi_i = 0; deq_v_i = 0; deq_cnt_i = 0;
        roll_v_i = 0; clr_v_i = 0;
        m_v_i = 0; m_data_i = 0; m_yumi_i = 0; m_deq_v_i = 0; m_deq_cnt_i = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_n_i = 1;

        // Reset state
        chk("rst_v", v_o, 0);
        chk("rst_occ", occupancy_o, 0);
        chk("rst_infl", inflight_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_m_ready", m_ready_o, 1);

        // Fill to full, then drain with 2-wide commits
        for (int i = 0; i < 16; i++) begin
            cyc(1, 64'h100 + 64'(i), 0, 0, 0, 0, 0);
            if (i == 14) chk("fill_ready_15", ready_o, 1);
        end
        chk("fill_ready_16", ready_o, 0);
        chk("fill_occ_16", occupancy_o, 16);
        chk("fill_head", data_o, 64'h100);
        chk_state("fill");
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        chk("drain_infl", inflight_o, 16);
        chk("drain_v", v_o, 0);
        cyc(0, 0, 0, 1, 2, 0, 0);
        chk("commit2_ready", ready_o, 1);
        chk("commit2_occ", occupancy_o, 14);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 2, 0, 0);
        chk_state("drained");

        // Replay: A..E in, A..D issued, commit A,B with roll
        for (int i = 0; i < 5; i++) cyc(1, 64'hA + 64'(i), 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 1, 0);
        chk("roll_data", data_o, 64'hC);
        chk("roll_infl", inflight_o, 0);
        chk("roll_occ", occupancy_o, 3);
        chk("roll_v", v_o, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk_state("roll_done");

        // Clear with same-cycle commit and enqueue
        for (int i = 0; i < 6; i++) cyc(1, 64'h200 + 64'(i), 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(1, 64'hDEAD, 0, 1, 2, 0, 1);
        chk("clr_occ", occupancy_o, 0);
        chk("clr_v", v_o, 0);
        chk("clr_infl", inflight_o, 0);
        chk("clr_ready", ready_o, 1);
        cyc(1, 64'h300, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk_state("clr_done");

        // Wrap: streaming enqueue/issue/commit, pointers wrap more than twice
        begin
            int base;
            base = issued;
            for (int k = 0; k < 40; k++)
                cyc(1, 64'h1000 + 64'(k), exp_q.size() != 0, infl >= 1, 1, 0, 0);
            for (int k = 0; k < 8 && (exp_q.size() != 0 || infl != 0); k++)
                cyc(0, 0, exp_q.size() != 0, infl >= 1, 1, 0, 0);
            chk("wrap_issued", 64'(issued - base), 40);
            chk("wrap_occ", occupancy_o, 0);
            chk_state("wrap_done");
        end

        // Margin instance: ready falls at occupancy 14
        for (int i = 0; i < 14; i++) begin
            m_v_i = 1; m_data_i = 64'h500 + 64'(i);
            @(posedge clk_i); #1;
            m_v_i = 0;
            if (i == 12) chk("margin_ready_13", m_ready_o, 1);
        end
        chk("margin_ready_14", m_ready_o, 0);
        chk("margin_occ_14", m_occupancy_o, 14);
        chk("margin_head", m_data_o, 64'h500);
        m_yumi_i = 1;
        @(posedge clk_i); #1;
        chk("margin_second", m_data_o, 64'h501);
        @(posedge clk_i); #1;
        m_yumi_i = 0;
        chk("margin_infl", m_inflight_o, 2);
        chk("margin_ready_still_low", m_ready_o, 0);
        m_deq_v_i = 1; m_deq_cnt_i = 2;
        @(posedge clk_i); #1;
        m_deq_v_i = 0; m_deq_cnt_i = 0;
        chk("margin_occ_12", m_occupancy_o, 12);
        chk("margin_ready_rise", m_ready_o, 1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) cyc(1, 64'h600 + 64'(i), 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        #3;
        reset_n_i = 0;
        #1;
        chk("arst_v", v_o, 0);
        chk("arst_occ", occupancy_o, 0);
        chk("arst_infl", inflight_o, 0);
        chk("arst_ready", ready_o, 1);
        chk("arst_m_occ", m_occupancy_o, 0);
        uc.delete();
        exp_q.delete();
        infl = 0;
        @(posedge clk_i);
        #3;
        reset_n_i = 1;
        @(posedge clk_i);
        #1;
        cyc(1, 64'h700, 0, 0, 0, 0, 0);
        chk("post_rst_data", data_o, 64'h700);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk_state("post_rst");
        chk("final_exp_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
